// File: rtl/tspi_shift_engine_if.sv
// Command/response port bundle for the TSPI shift engine.
// The master side drives commands and accepts responses; the slave side is the engine.
interface tspi_shift_engine_if #(
  parameter int DataWidth = 32,
  parameter int BeatW     = $clog2(DataWidth)
);
  logic                 cmd_valid_i;
  logic                 cmd_ready_o;
  logic [DataWidth-1:0] cmd_data_i;
  logic [1:0]           cmd_lanes_i;
  logic [BeatW-1:0]     cmd_tx_beats_i;
  logic                 cmd_rx_en_i;
  logic [BeatW-1:0]     cmd_rx_beats_i;
  logic                 rsp_valid_o;
  logic                 rsp_ready_i;
  logic [DataWidth-1:0] rsp_data_o;
  logic                 rsp_timeout_o;

  modport master (
    output cmd_valid_i, cmd_data_i, cmd_lanes_i, cmd_tx_beats_i, cmd_rx_en_i,
           cmd_rx_beats_i, rsp_ready_i,
    input  cmd_ready_o, rsp_valid_o, rsp_data_o, rsp_timeout_o
  );

  modport slave (
    input  cmd_valid_i, cmd_data_i, cmd_lanes_i, cmd_tx_beats_i, cmd_rx_en_i,
           cmd_rx_beats_i, rsp_ready_i,
    output cmd_ready_o, rsp_valid_o, rsp_data_o, rsp_timeout_o
  );
endinterface

// File: rtl/tspi_shift_engine.sv
// TSPI shift engine: shifts a command out over 1/2/4 lanes, waits for a start bit,
// shifts a response in. Optional WAIT_START timeout: define TSPI_SHIFT_TIMEOUT_EN.
module tspi_shift_engine #(
  parameter int DataWidth    = 32,
  parameter int MaxLanes     = 4,
  parameter int TimeoutTicks = 1024,
  parameter int BeatW        = $clog2(DataWidth)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                shift_en_i,
  input  logic                abort_i,
  output logic [MaxLanes-1:0] mosi_o,
  input  logic [MaxLanes-1:0] miso_i,
  output logic                busy_o,
  tspi_shift_engine_if.slave  bus
);
  localparam int CntW = BeatW + 1;
  localparam logic [1:0] MaxLog = (MaxLanes >= 4) ? 2'd2 : (MaxLanes >= 2) ? 2'd1 : 2'd0;

  typedef enum logic [2:0] {IDLE, TX, WAIT_START, RX, DONE} state_t;

  state_t               state;
  logic [DataWidth-1:0] sreg, sreg_next;
  logic [DataWidth-1:0] rx_q, rx_next;
  logic [1:0]           lsel, lsel_new;
  logic [CntW-1:0]      cnt, rx_beats, tx_beats_new, rx_beats_new;
  logic                 rx_en;
  logic                 cmd_ready_q, rsp_valid_q, busy_q;
  logic [3:0]           miso4, mosi4;

  // Lane count is held as log2(L) so shifts and beat limits stay simple.
  function automatic logic [CntW-1:0] clamp_beats(input logic [BeatW-1:0] f,
                                                  input logic [1:0] ls);
    logic [CntW-1:0] b, lim;
    b   = CntW'(f) + CntW'(1);
    lim = CntW'(DataWidth >> ls);
    return (b > lim) ? lim : b;
  endfunction

  always_comb begin
    lsel_new = 2'd0;
    case (bus.cmd_lanes_i)
      2'd1:    lsel_new = 2'd1;
      2'd2:    lsel_new = 2'd2;
      default: lsel_new = 2'd0;
    endcase
    if (lsel_new > MaxLog) lsel_new = MaxLog;
    tx_beats_new = clamp_beats(bus.cmd_tx_beats_i, lsel_new);
    rx_beats_new = clamp_beats(bus.cmd_rx_beats_i, lsel_new);
  end

  assign miso4 = 4'(miso_i);

  always_comb begin
    sreg_next = {sreg[DataWidth-2:0], 1'b0};
    rx_next   = {rx_q[DataWidth-2:0], miso4[0]};
    mosi4     = '1;
    case (lsel)
      2'd1: begin
        sreg_next = {sreg[DataWidth-3:0], 2'b00};
        rx_next   = {rx_q[DataWidth-3:0], miso4[1:0]};
      end
      2'd2: begin
        sreg_next = {sreg[DataWidth-5:0], 4'b0000};
        rx_next   = {rx_q[DataWidth-5:0], miso4};
      end
      default: ;
    endcase
    if (state == TX) begin
      case (lsel)
        2'd1:    mosi4[1:0] = sreg[DataWidth-1 -: 2];
        2'd2:    mosi4      = sreg[DataWidth-1 -: 4];
        default: mosi4[0]   = sreg[DataWidth-1];
      endcase
    end
  end

  assign mosi_o          = mosi4[MaxLanes-1:0];
  assign busy_o          = busy_q;
  assign bus.cmd_ready_o = cmd_ready_q;
  assign bus.rsp_valid_o = rsp_valid_q;
  assign bus.rsp_data_o  = rx_q;

`ifdef TSPI_SHIFT_TIMEOUT_EN
  localparam int TW = $clog2(TimeoutTicks + 1);
  logic [TW-1:0] tcnt;
  logic          timeout_q;
  assign bus.rsp_timeout_o = timeout_q;
`else
  assign bus.rsp_timeout_o = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      sreg        <= '0;
      rx_q        <= '0;
      cnt         <= '0;
      rx_beats    <= '0;
      lsel        <= '0;
      rx_en       <= 1'b0;
`ifdef TSPI_SHIFT_TIMEOUT_EN
      tcnt        <= '0;
      timeout_q   <= 1'b0;
`endif
    end else if (abort_i) begin
      state       <= IDLE;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.cmd_valid_i) begin
          state       <= TX;
          cmd_ready_q <= 1'b0;
          busy_q      <= 1'b1;
          sreg        <= bus.cmd_data_i;
          rx_q        <= '0;
          cnt         <= tx_beats_new;
          rx_beats    <= rx_beats_new;
          lsel        <= lsel_new;
          rx_en       <= bus.cmd_rx_en_i;
`ifdef TSPI_SHIFT_TIMEOUT_EN
          timeout_q   <= 1'b0;
`endif
        end
        TX: if (shift_en_i) begin
          sreg <= sreg_next;
          cnt  <= cnt - CntW'(1);
          if (cnt == CntW'(1)) begin
            if (rx_en) begin
              state <= WAIT_START;
`ifdef TSPI_SHIFT_TIMEOUT_EN
              tcnt  <= '0;
`endif
            end else begin
              state       <= DONE;
              rsp_valid_q <= 1'b1;
            end
          end
        end
        // A start bit wins over a terminal timeout count on the same tick.
        WAIT_START: if (shift_en_i) begin
          if (!miso_i[0]) begin
            state <= RX;
            cnt   <= rx_beats;
          end
`ifdef TSPI_SHIFT_TIMEOUT_EN
          else if (tcnt == TW'(TimeoutTicks - 1)) begin
            state       <= DONE;
            rsp_valid_q <= 1'b1;
            timeout_q   <= 1'b1;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
`endif
        end
        RX: if (shift_en_i) begin
          rx_q <= rx_next;
          cnt  <= cnt - CntW'(1);
          if (cnt == CntW'(1)) begin
            state       <= DONE;
            rsp_valid_q <= 1'b1;
          end
        end
        DONE: if (bus.rsp_ready_i) begin
          state       <= IDLE;
          cmd_ready_q <= 1'b1;
          rsp_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
